// File: rtl/decode_issue_stage.sv
// Decode/issue stage: RV32 decode, bypass operand select, MUL-latency scoreboard,
// RAW/WAW stall and a single registered output packet with valid/ready handshake.

module dis_operand #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5,
  parameter int NUM_BYPASS     = 4
) (
  input  logic                                 need_i,
  input  logic [REGISTER_WIDTH-1:0]            rs_i,
  input  logic [DATA_WIDTH-1:0]                rf_data_i,
  input  logic                                 busy_i,
  input  logic [NUM_BYPASS-1:0]                byp_valid_i,
  input  logic [NUM_BYPASS-1:0]                byp_ready_i,
  input  logic [NUM_BYPASS*REGISTER_WIDTH-1:0] byp_reg_i,
  input  logic [NUM_BYPASS*DATA_WIDTH-1:0]     byp_data_i,
  output logic [DATA_WIDTH-1:0]                op_o,
  output logic                                 haz_o
);
  logic                  nz, hit, hit_rdy, any_rdy, match;
  logic [DATA_WIDTH-1:0] sel_data;

  assign nz = (rs_i != '0);

  // Walk from the oldest source down so the youngest match is the last writer.
  always_comb begin
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    any_rdy  = 1'b0;
    sel_data = rf_data_i;
    match    = 1'b0;
    for (int i = NUM_BYPASS-1; i >= 0; i--) begin
      match = nz & byp_valid_i[i] & (byp_reg_i[i*REGISTER_WIDTH +: REGISTER_WIDTH] == rs_i);
      if (match) begin
        hit      = 1'b1;
        hit_rdy  = byp_ready_i[i];
        sel_data = byp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
      any_rdy = any_rdy | (match & byp_ready_i[i]);
    end
  end

  assign op_o  = nz ? sel_data : '0;
  assign haz_o = need_i & nz & ((hit & ~hit_rdy) | (busy_i & ~any_rdy));
endmodule

module decode_issue_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5,
  parameter int NUM_BYPASS     = 4,
  parameter int MUL_LATENCY    = 5
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic [31:0]                          instr_i,
  input  logic                                 flush_i,
  input  logic [DATA_WIDTH-1:0]                rs1_data_i,
  input  logic [DATA_WIDTH-1:0]                rs2_data_i,
  input  logic [NUM_BYPASS-1:0]                byp_valid_i,
  input  logic [NUM_BYPASS-1:0]                byp_ready_i,
  input  logic [NUM_BYPASS*REGISTER_WIDTH-1:0] byp_reg_i,
  input  logic [NUM_BYPASS*DATA_WIDTH-1:0]     byp_data_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 out_is_mul_o,
  output logic                                 out_is_wb_o,
  output logic [REGISTER_WIDTH-1:0]            out_wr_reg_o,
  output logic [DATA_WIDTH-1:0]                out_rs1_o,
  output logic [DATA_WIDTH-1:0]                out_rs2_o,
  output logic [DATA_WIDTH-1:0]                out_imm_o,
  output logic [5:0]                           out_shamt_o,
  output logic                                 stall_o
);
  localparam int NUM_REGS = 2**REGISTER_WIDTH;
  localparam int CW       = $clog2(MUL_LATENCY+1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  typedef struct packed {
    logic                      is_mul;
    logic                      is_wb;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0]     rs1;
    logic [DATA_WIDTH-1:0]     rs2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [5:0]                shamt;
  } pkt_t;

  pkt_t  pkt_d, pkt_q;
  logic  out_valid_q;
  logic [CW-1:0]       sb_q [NUM_REGS];
  logic [CW-1:0]       sb_d [NUM_REGS];
  logic [NUM_REGS-1:0] sb_busy;

  logic [6:0] opc;
  logic       is_r, is_ld, is_st, is_br, is_imm, is_jal, is_jalr, is_lui, is_aui;
  logic       need1, need2, dec_wb, dec_mul;
  logic [REGISTER_WIDTH-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [31:0] imm32;
  logic [1:0]  op_need, op_haz, op_busy;
  logic [1:0][REGISTER_WIDTH-1:0] op_rs;
  logic [1:0][DATA_WIDTH-1:0]     op_rf, op_val;
  logic        waw, hazard, accept, mul_hs;

  assign opc     = instr_i[6:0];
  assign is_r    = (opc == OP_R);
  assign is_ld   = (opc == OP_LD);
  assign is_st   = (opc == OP_ST);
  assign is_br   = (opc == OP_BR);
  assign is_imm  = (opc == OP_IMM);
  assign is_jal  = (opc == OP_JAL);
  assign is_jalr = (opc == OP_JALR);
  assign is_lui  = (opc == OP_LUI);
  assign is_aui  = (opc == OP_AUI);

  assign rs1_idx = REGISTER_WIDTH'(instr_i[19:15]);
  assign rs2_idx = REGISTER_WIDTH'(instr_i[24:20]);
  assign rd_idx  = REGISTER_WIDTH'(instr_i[11:7]);

  assign need1   = is_r | is_ld | is_st | is_br | is_imm;
  assign need2   = is_r | is_st | is_br;
  assign dec_wb  = is_r | is_ld | is_imm | is_jal | is_lui | is_aui;
  assign dec_mul = is_r & (instr_i[14:12] == 3'b000) & (instr_i[31:25] == 7'b0000001);

  always_comb begin
    imm32 = '0;
    if (is_ld | is_imm | is_jalr) imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
    else if (is_st)  imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    else if (is_br)  imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
    else if (is_jal) imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
    else if (is_lui | is_aui) imm32 = {instr_i[31:12], 12'b0};
  end

  assign op_need = {need2, need1};
  assign op_rs   = {rs2_idx, rs1_idx};
  assign op_rf   = {rs2_data_i, rs1_data_i};

  for (genvar g = 0; g < 2; g++) begin : g_op
    assign op_busy[g] = sb_busy[op_rs[g]];
    dis_operand #(
      .DATA_WIDTH(DATA_WIDTH), .REGISTER_WIDTH(REGISTER_WIDTH), .NUM_BYPASS(NUM_BYPASS)
    ) u_op (
      .need_i     (op_need[g]),
      .rs_i       (op_rs[g]),
      .rf_data_i  (op_rf[g]),
      .busy_i     (op_busy[g]),
      .byp_valid_i(byp_valid_i),
      .byp_ready_i(byp_ready_i),
      .byp_reg_i  (byp_reg_i),
      .byp_data_i (byp_data_i),
      .op_o       (op_val[g]),
      .haz_o      (op_haz[g])
    );
  end

  assign waw    = dec_wb & sb_busy[rd_idx];
  assign hazard = op_haz[0] | op_haz[1] | waw;

  assign ready_o = flush_i | (~hazard & (~out_valid_q | out_ready_i));
  assign stall_o = valid_i & hazard & ~flush_i;
  assign accept  = valid_i & ready_o;

  always_comb begin
    pkt_d        = '0;
    pkt_d.is_mul = dec_mul;
    pkt_d.is_wb  = dec_wb;
    pkt_d.wr_reg = rd_idx;
    pkt_d.rs1    = op_val[0];
    pkt_d.rs2    = op_val[1];
    pkt_d.imm    = DATA_WIDTH'(signed'(imm32));
    pkt_d.shamt  = is_imm ? {instr_i[25], instr_i[24:20]} : 6'd0;
  end

  // Scoreboard is armed when execute takes the MUL, not when it is decoded.
  assign mul_hs = out_valid_q & out_ready_i & pkt_q.is_mul & (pkt_q.wr_reg != '0);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_busy[r] = (sb_q[r] != '0);
      sb_d[r]    = sb_busy[r] ? sb_q[r] - CW'(1) : '0;
    end
    if (mul_hs) sb_d[pkt_q.wr_reg] = CW'(MUL_LATENCY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      pkt_q       <= '0;
      for (int r = 0; r < NUM_REGS; r++) sb_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) sb_q[r] <= sb_d[r];
      if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        pkt_q       <= pkt_d;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_is_mul_o = pkt_q.is_mul;
  assign out_is_wb_o  = pkt_q.is_wb;
  assign out_wr_reg_o = pkt_q.wr_reg;
  assign out_rs1_o    = pkt_q.rs1;
  assign out_rs2_o    = pkt_q.rs2;
  assign out_imm_o    = pkt_q.imm;
  assign out_shamt_o  = pkt_q.shamt;
endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: expected packets queued on accept, compared on handshake.

module tb_decode_issue_stage;
  localparam int DW = 32, RW = 5, NB = 4, ML = 5;
  localparam logic [6:0] OPI = 7'b0010011;

  logic clk_i = 1'b0;
  logic rst_i, valid_i, ready_o, flush_i, out_valid_o, out_ready_i;
  logic out_is_mul_o, out_is_wb_o, stall_o;
  logic [31:0] instr_i;
  logic [DW-1:0] rs1_data_i, rs2_data_i, out_rs1_o, out_rs2_o, out_imm_o;
  logic [NB-1:0] byp_valid_i, byp_ready_i;
  logic [NB*RW-1:0] byp_reg_i;
  logic [NB*DW-1:0] byp_data_i;
  logic [RW-1:0] out_wr_reg_o;
  logic [5:0] out_shamt_o;

  typedef struct packed {
    logic          is_mul;
    logic          is_wb;
    logic [RW-1:0] wr;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [DW-1:0] imm;
    logic [5:0]    shamt;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t exp_cur, got, ex;
  int checks = 0, failures = 0;

  always #5 clk_i = ~clk_i;

  decode_issue_stage #(.DATA_WIDTH(DW), .REGISTER_WIDTH(RW), .NUM_BYPASS(NB), .MUL_LATENCY(ML)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .instr_i(instr_i),
    .flush_i(flush_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .byp_valid_i(byp_valid_i), .byp_ready_i(byp_ready_i), .byp_reg_i(byp_reg_i),
    .byp_data_i(byp_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_is_mul_o(out_is_mul_o), .out_is_wb_o(out_is_wb_o), .out_wr_reg_o(out_wr_reg_o),
    .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o), .out_imm_o(out_imm_o),
    .out_shamt_o(out_shamt_o), .stall_o(stall_o)
  );

  assign got = '{out_is_mul_o, out_is_wb_o, out_wr_reg_o, out_rs1_o, out_rs2_o, out_imm_o, out_shamt_o};

  // Scoreboard: pop on handshake (or drop on flush), then push whatever decode accepts.
  always @(negedge clk_i) begin
    if (rst_i) exp_q.delete();
    else begin
      if (out_valid_o && (out_ready_i || flush_i)) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pkt got=%h exp=none", got);
        end else begin
          ex = exp_q.pop_front();
          if (out_ready_i) begin
            checks++;
            if (got !== ex) begin
              failures++;
              $display("FAIL pkt got=%h exp=%h", got, ex);
            end
          end
        end
      end
      if (valid_i && ready_o && !flush_i) exp_q.push_back(exp_cur);
    end
  end

  task automatic cyc(); @(posedge clk_i); #1; endtask

  function automatic pkt_t mk(logic m, logic w, logic [RW-1:0] rd, logic [DW-1:0] a,
                              logic [DW-1:0] b, logic [DW-1:0] imm, logic [5:0] sh);
    pkt_t p;
    p = '{m, w, rd, a, b, imm, sh};
    return p;
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, OPI};
  endfunction

  task automatic clr_byp();
    byp_valid_i = '0; byp_ready_i = '0; byp_reg_i = '0; byp_data_i = '0;
  endtask

  task automatic set_byp(int i, logic rdy, logic [RW-1:0] r, logic [DW-1:0] d);
    byp_valid_i[i] = 1'b1;
    byp_ready_i[i] = rdy;
    byp_reg_i[i*RW +: RW] = r;
    byp_data_i[i*DW +: DW] = d;
  endtask

  task automatic drive(logic [31:0] ins, logic [DW-1:0] a, logic [DW-1:0] b, pkt_t e);
    valid_i = 1'b1; instr_i = ins; rs1_data_i = a; rs2_data_i = b; exp_cur = e;
  endtask

  task automatic idle();
    valid_i = 1'b0; instr_i = '0; rs1_data_i = '0; rs2_data_i = '0;
  endtask

  task automatic count_stalls(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (ready_o) break;
      n++;
      cyc();
    end
  endtask

  task automatic test_reset();
    idle(); clr_byp(); flush_i = 0; out_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_init got=%b%b exp=01", out_valid_o, ready_o);
    end
    cyc();
    drive(enc_r(7'h01, 2, 1, 3), 3, 4, mk(1, 1, 3, 3, 4, 0, 0)); cyc();
    idle(); cyc();
    out_ready_i = 0;
    drive(enc_i(12'd7, 0, 5), 0, 0, mk(0, 1, 5, 0, 0, 7, 7)); cyc();
    idle();
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b1) begin
      failures++; $display("FAIL pre_reset_valid got=%b exp=1", out_valid_o);
    end
    rst_i = 1; cyc(); cyc(); cyc(); rst_i = 0;
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0 || got !== '0 || ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_out got=%b %h rdy=%b exp=0 0 1", out_valid_o, got, ready_o);
    end
    out_ready_i = 1;
    drive(enc_r(7'h00, 3, 3, 4), 0, 0, mk(0, 1, 4, 0, 0, 0, 0));
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || stall_o !== 1'b0) begin
      failures++; $display("FAIL reset_sb_clear got=%b%b exp=10", ready_o, stall_o);
    end
    cyc(); idle(); cyc();
  endtask

  task automatic test_bypass();
    clr_byp(); out_ready_i = 1;
    drive(enc_i(12'd7, 0, 5), 0, 0, mk(0, 1, 5, 0, 0, 7, 7));
    cyc();
    set_byp(0, 1, 5, 32'd7); set_byp(1, 1, 5, 32'd9);
    drive(enc_r(7'h00, 5, 5, 6), 32'h111, 32'h222, mk(0, 1, 6, 7, 7, 0, 0));
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0 || ready_o !== 1'b1 || out_valid_o !== 1'b1) begin
      failures++; $display("FAIL byp_b2b_a got=%b%b%b exp=011", stall_o, ready_o, out_valid_o);
    end
    cyc(); idle(); clr_byp();
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b1) begin
      failures++; $display("FAIL byp_b2b_b got=%b exp=1", out_valid_o);
    end
    cyc();
  endtask

  task automatic test_load_stall();
    clr_byp(); out_ready_i = 1;
    set_byp(1, 0, 5, 32'hBAD);
    drive(enc_r(7'h00, 1, 5, 6), 32'h333, 32'h22, mk(0, 1, 6, 32'h55, 32'h22, 0, 0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      checks++;
      if (stall_o !== 1'b1 || ready_o !== 1'b0) begin
        failures++; $display("FAIL load_stall cyc=%0d got=%b%b exp=10", k, stall_o, ready_o);
      end
      cyc();
    end
    byp_ready_i[1] = 1'b1; byp_data_i[1*DW +: DW] = 32'h55;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || stall_o !== 1'b0) begin
      failures++; $display("FAIL load_release got=%b%b exp=10", ready_o, stall_o);
    end
    cyc(); idle(); clr_byp();
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b1) begin
      failures++; $display("FAIL load_issue got=%b exp=1", out_valid_o);
    end
    cyc();
  endtask

  task automatic test_mul_scoreboard();
    int n;
    clr_byp(); out_ready_i = 1;
    drive(enc_r(7'h01, 2, 1, 3), 3, 4, mk(1, 1, 3, 3, 4, 0, 0)); cyc();
    idle(); cyc();
    drive(enc_r(7'h00, 3, 3, 4), 0, 0, mk(0, 1, 4, 0, 0, 0, 0));
    count_stalls(n);
    checks++;
    if (n != ML) begin
      failures++; $display("FAIL mul_stall_len got=%0d exp=%0d", n, ML);
    end
    cyc(); idle(); cyc();
    drive(enc_r(7'h01, 2, 1, 3), 3, 4, mk(1, 1, 3, 3, 4, 0, 0)); cyc();
    idle(); cyc();
    drive(enc_r(7'h00, 3, 3, 4), 0, 0, mk(0, 1, 4, 32'h77, 32'h77, 0, 0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      checks++;
      if (stall_o !== 1'b1) begin
        failures++; $display("FAIL mul_window cyc=%0d got=%b exp=1", k, stall_o);
      end
      cyc();
    end
    set_byp(2, 1, 3, 32'h77);
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || stall_o !== 1'b0) begin
      failures++; $display("FAIL mul_byp_release got=%b%b exp=10", ready_o, stall_o);
    end
    cyc(); idle(); clr_byp();
    repeat (6) cyc();
  endtask

  task automatic test_waw();
    int n;
    out_ready_i = 1;
    drive(enc_r(7'h01, 2, 1, 20), 3, 4, mk(1, 1, 20, 3, 4, 0, 0)); cyc();
    idle(); cyc();
    drive(enc_i(12'd1, 0, 20), 0, 0, mk(0, 1, 20, 0, 0, 1, 1));
    count_stalls(n);
    checks++;
    if (n != ML) begin
      failures++; $display("FAIL waw_stall_len got=%0d exp=%0d", n, ML);
    end
    cyc(); idle(); cyc();
  endtask

  task automatic test_hold();
    pkt_t a;
    clr_byp(); out_ready_i = 0;
    a = mk(0, 1, 9, 32'h10, 0, 32'hFFFF_FFFB, 6'h3B);
    drive(enc_i(12'hFFB, 1, 9), 32'h10, 0, a); cyc();
    drive({20'hABCDE, 5'd11, 7'b0110111}, 0, 0, mk(0, 1, 11, 0, 0, 32'hABCD_E000, 0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      checks++;
      if (ready_o !== 1'b0 || out_valid_o !== 1'b1 || got !== a) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d got=%b%b %h exp=01 %h", k, ready_o, out_valid_o, got, a);
      end
      cyc();
    end
    out_ready_i = 1;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin
      failures++; $display("FAIL hold_release got=%b exp=1", ready_o);
    end
    cyc(); idle(); cyc();
  endtask

  task automatic test_formats();
    logic [31:0] ins [8];
    logic [DW-1:0] ra [8];
    logic [DW-1:0] rb [8];
    pkt_t e [8];
    clr_byp(); out_ready_i = 1;
    ins[0] = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h18, 7'b0100011}; ra[0] = 32'hA; rb[0] = 32'hB;
    e[0]   = mk(0, 0, 24, 32'hA, 32'hB, 32'hFFFF_FFF8, 0);
    ins[1] = {1'b1, 6'h3F, 5'd2, 5'd1, 3'b000, 4'h8, 1'b1, 7'b1100011}; ra[1] = 32'hC; rb[1] = 32'hD;
    e[1]   = mk(0, 0, 17, 32'hC, 32'hD, 32'hFFFF_FFF0, 0);
    ins[2] = {1'b0, 10'h0, 1'b1, 8'h00, 5'd1, 7'b1101111}; ra[2] = 0; rb[2] = 0;
    e[2]   = mk(0, 1, 1, 0, 0, 32'h800, 0);
    ins[3] = {20'h80000, 5'd12, 7'b0010111}; ra[3] = 0; rb[3] = 0;
    e[3]   = mk(0, 1, 12, 0, 0, 32'h8000_0000, 0);
    ins[4] = {7'h01, 5'd1, 5'd1, 3'b001, 5'd13, OPI}; ra[4] = 32'h5; rb[4] = 0;
    e[4]   = mk(0, 1, 13, 32'h5, 0, 32'd33, 6'd33);
    ins[5] = {12'hFFF, 5'd3, 3'b010, 5'd14, 7'b0000011}; ra[5] = 32'h30; rb[5] = 0;
    e[5]   = mk(0, 1, 14, 32'h30, 0, 32'hFFFF_FFFF, 0);
    ins[6] = {20'h12345, 5'd15, 7'b0110111}; ra[6] = 0; rb[6] = 0;
    e[6]   = mk(0, 1, 15, 0, 0, 32'h1234_5000, 0);
    ins[7] = enc_r(7'h01, 2, 1, 16); ra[7] = 32'h6; rb[7] = 32'h7;
    e[7]   = mk(1, 1, 16, 32'h6, 32'h7, 0, 0);
    for (int k = 0; k < 8; k++) begin
      drive(ins[k], ra[k], rb[k], e[k]);
      @(negedge clk_i);
      checks++;
      if (ready_o !== 1'b1) begin
        failures++; $display("FAIL fmt_accept idx=%0d got=%b exp=1", k, ready_o);
      end
      cyc();
    end
    idle(); cyc(); cyc();
  endtask

  task automatic test_flush();
    int n;
    clr_byp(); out_ready_i = 1;
    drive(enc_r(7'h01, 2, 1, 7), 1, 2, mk(1, 1, 7, 1, 2, 0, 0)); cyc();
    idle(); cyc();
    out_ready_i = 0;
    drive(enc_i(12'd3, 0, 9), 0, 0, mk(0, 1, 9, 0, 0, 3, 3)); cyc();
    drive(enc_i(12'd1, 0, 10), 0, 0, mk(0, 1, 10, 0, 0, 1, 1));
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b0) begin
      failures++; $display("FAIL flush_hold got=%b exp=0", ready_o);
    end
    cyc();
    flush_i = 1;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || stall_o !== 1'b0) begin
      failures++; $display("FAIL flush_ready got=%b%b exp=10", ready_o, stall_o);
    end
    cyc();
    flush_i = 0; out_ready_i = 1;
    drive(enc_r(7'h00, 7, 7, 8), 0, 0, mk(0, 1, 8, 0, 0, 0, 0));
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++; $display("FAIL flush_kill got=%b exp=0", out_valid_o);
    end
    count_stalls(n);
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL flush_sb_count got=%0d exp=2", n);
    end
    cyc(); idle(); cyc();
  endtask

  task automatic test_x0();
    clr_byp(); out_ready_i = 1;
    set_byp(0, 1, 0, 32'hDEAD);
    drive(enc_r(7'h00, 2, 1, 0), 32'h1, 32'h2, mk(0, 1, 0, 32'h1, 32'h2, 0, 0));
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin
      failures++; $display("FAIL x0_dest got=%b exp=1", ready_o);
    end
    cyc();
    byp_ready_i[0] = 1'b0;
    drive(enc_r(7'h00, 2, 0, 7), 32'h99, 32'h2, mk(0, 1, 7, 0, 32'h2, 0, 0));
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1 || stall_o !== 1'b0) begin
      failures++; $display("FAIL x0_src got=%b%b exp=10", ready_o, stall_o);
    end
    cyc(); idle(); clr_byp(); cyc(); cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1; flush_i = 0; out_ready_i = 0; idle(); clr_byp(); exp_cur = '0;
    cyc(); cyc(); cyc();
    rst_i = 0;
    test_reset();
    test_bypass();
    test_load_stall();
    test_mul_scoreboard();
    test_waw();
    test_hold();
    test_formats();
    test_flush();
    test_x0();
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
